// File: rtl/lpddr2_avm_arbiter.sv
// Two-port arbiter onto the LPDDR2 controller Avalon-MM port, with in-order read tag tracking.
// Optional round-robin arbitration enabled by defining LPDDR2_ARB_RR_EN (default: fixed priority, port 0 wins).
module lpddr2_avm_arbiter #(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned TAG_PTR_W = 3
) (
  input  logic                  avm_clk,
  input  logic                  avm_rst_n,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  input  logic                  m0_read_req,
  input  logic                  m0_write_req,
  output logic                  m0_ready,
  output logic                  m0_rdata_valid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  input  logic                  m1_read_req,
  input  logic                  m1_write_req,
  output logic                  m1_ready,
  output logic                  m1_rdata_valid,
  output logic [DATA_W-1:0]     m1_rdata,
  input  logic                  avm_ready,
  output logic                  avm_burstbegin,
  output logic [ADDR_W-1:0]     avm_addr,
  output logic [DATA_W-1:0]     avm_wdata,
  output logic [DATA_W/8-1:0]   avm_be,
  output logic                  avm_read_req,
  output logic                  avm_write_req,
  output logic                  avm_size,
  input  logic                  avm_rdata_valid,
  input  logic [DATA_W-1:0]     avm_rdata,
  output logic                  arb_err
);

  localparam logic [TAG_PTR_W:0] FULL_CNT = (TAG_PTR_W+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD0, S_HOLD1} state_e;

  state_e                 state_q, state_d;
  logic [TAG_DEPTH-1:0]   tag_q, tag_d;
  logic [TAG_PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_PTR_W:0]     count_q, count_d;
  logic                   arb_err_q, arb_err_d;

  logic tag_full, elig0, elig1;
  logic grant_vld, grant_id, win_rd, accept, push, pop, head;

`ifdef LPDDR2_ARB_RR_EN
  logic last_q, last_d;
`endif

  // Arbitration, command mux and read-tag bookkeeping
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    avm_burstbegin = 1'b0;

    tag_full = (count_q == FULL_CNT);
    elig0    = m0_read_req ? !tag_full : m0_write_req;
    elig1    = m1_read_req ? !tag_full : m1_write_req;

    unique case (state_q)
      S_IDLE: begin
        grant_vld      = elig0 | elig1;
        avm_burstbegin = elig0 | elig1;
        if (elig0 && elig1) begin
`ifdef LPDDR2_ARB_RR_EN
          grant_id = !last_q;
`else
          grant_id = 1'b0;
`endif
        end else begin
          grant_id = !elig0;
        end
      end
      S_HOLD0: begin
        grant_vld = elig0;
        grant_id  = 1'b0;
      end
      S_HOLD1: begin
        grant_vld = elig1;
        grant_id  = 1'b1;
      end
      default: ;
    endcase

    win_rd = grant_id ? m1_read_req : m0_read_req;
    accept = grant_vld & avm_ready;
    push   = accept & win_rd;
    pop    = avm_rdata_valid & (count_q != '0);
    head   = tag_q[rd_ptr_q];

    avm_addr      = grant_id ? m1_addr  : m0_addr;
    avm_wdata     = grant_id ? m1_wdata : m0_wdata;
    avm_be        = grant_id ? m1_be    : m0_be;
    avm_read_req  = grant_vld & win_rd;
    avm_write_req = grant_vld & !win_rd;
    avm_size      = 1'b1;
    m0_ready      = accept & !grant_id;
    m1_ready      = accept & grant_id;
    m0_rdata_valid = pop & !head;
    m1_rdata_valid = pop & head;
    arb_err        = arb_err_q;

    // A stalled grant locks the mux; a dropped request falls back to IDLE
    if (grant_vld && !avm_ready) state_d = grant_id ? S_HOLD1 : S_HOLD0;
    else                         state_d = S_IDLE;

    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      tag_d[wr_ptr_q] = grant_id;
      wr_ptr_d        = wr_ptr_q + TAG_PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + TAG_PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (TAG_PTR_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_PTR_W+1)'(1);
      default: ;
    endcase

    arb_err_d = arb_err_q | (avm_rdata_valid & (count_q == '0));

`ifdef LPDDR2_ARB_RR_EN
    last_d = accept ? grant_id : last_q;
`endif
  end

  assign m0_rdata = avm_rdata;
  assign m1_rdata = avm_rdata;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      arb_err_q <= arb_err_d;
    end
  end

`ifdef LPDDR2_ARB_RR_EN
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) last_q <= 1'b1;
    else            last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_lpddr2_avm_arbiter.sv
// Self-checking bench for lpddr2_avm_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_lpddr2_avm_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef LPDDR2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [BW-1:0] be    [2];
  logic          rreq  [2];
  logic          wreq  [2];
  logic m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic avm_ready, avm_burstbegin, avm_read_req, avm_write_req, avm_size;
  logic [AW-1:0] avm_addr;
  logic [DW-1:0] avm_wdata;
  logic [BW-1:0] avm_be;
  logic avm_rdata_valid, arb_err;
  logic [DW-1:0] avm_rdata;

  lpddr2_avm_arbiter dut (
    .avm_clk(clk), .avm_rst_n(rst_n),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_be(be[0]),
    .m0_read_req(rreq[0]), .m0_write_req(wreq[0]),
    .m0_ready(m0_ready), .m0_rdata_valid(m0_rdata_valid), .m0_rdata(m0_rdata),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_be(be[1]),
    .m1_read_req(rreq[1]), .m1_write_req(wreq[1]),
    .m1_ready(m1_ready), .m1_rdata_valid(m1_rdata_valid), .m1_rdata(m1_rdata),
    .avm_ready(avm_ready), .avm_burstbegin(avm_burstbegin),
    .avm_addr(avm_addr), .avm_wdata(avm_wdata), .avm_be(avm_be),
    .avm_read_req(avm_read_req), .avm_write_req(avm_write_req), .avm_size(avm_size),
    .avm_rdata_valid(avm_rdata_valid), .avm_rdata(avm_rdata), .arb_err(arb_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: locked port, last winner, outstanding-read owner queue, sticky error
  int held = -1;
  bit last = 1'b1;
  int q[$];
  bit err = 1'b0;
  bit acc[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : model
    bit e[2];
    bit gv, bb, v0, v1;
    int gid;
    if (!rst_n) begin
      chk("rst_read_req", avm_read_req, 0);
      chk("rst_write_req", avm_write_req, 0);
      chk("rst_burst", avm_burstbegin, 0);
      chk("rst_ready", {m0_ready, m1_ready}, 0);
      chk("rst_rvalid", {m0_rdata_valid, m1_rdata_valid}, 0);
      chk("rst_err", arb_err, 0);
      chk("rst_size", avm_size, 1);
      held = -1; last = 1'b1; q.delete(); err = 1'b0; acc[0] = 1'b0; acc[1] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) e[p] = rreq[p] ? (q.size() < 8) : wreq[p];
      if (held >= 0) begin
        gid = held; gv = e[held]; bb = 1'b0;
      end else begin
        gv = e[0] | e[1];
        bb = gv;
        if (e[0] && e[1]) gid = (RR && !last) ? 1 : 0;
        else              gid = (e[1] && !e[0]) ? 1 : 0;
      end
      v0 = 1'b0; v1 = 1'b0;
      if (avm_rdata_valid && q.size() > 0) begin
        v0 = (q[0] == 0);
        v1 = (q[0] == 1);
      end
      chk("arb_err", arb_err, err);
      chk("burstbegin", avm_burstbegin, bb);
      chk("read_req", avm_read_req, gv && rreq[gid]);
      chk("write_req", avm_write_req, gv && !rreq[gid]);
      chk("m0_ready", m0_ready, gv && avm_ready && gid == 0);
      chk("m1_ready", m1_ready, gv && avm_ready && gid == 1);
      chk("avm_size", avm_size, 1);
      if (gv) begin
        chk("avm_addr", avm_addr, addr[gid]);
        chk("avm_wdata", avm_wdata, wdata[gid]);
        chk("avm_be", avm_be, be[gid]);
      end
      chk("m0_rdata_valid", m0_rdata_valid, v0);
      chk("m1_rdata_valid", m1_rdata_valid, v1);
      chk("m0_rdata", m0_rdata, avm_rdata);
      chk("m1_rdata", m1_rdata, avm_rdata);
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (avm_rdata_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        else              err = 1'b1;
      end
      if (gv && avm_ready) begin
        acc[gid] = 1'b1;
        if (rreq[gid]) q.push_back(gid);
        last = gid[0];
        held = -1;
      end else if (gv) begin
        held = gid;
      end else begin
        held = -1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      rreq[p] = 1'b0; wreq[p] = 1'b0;
    end
    avm_rdata_valid = 1'b0;
  endtask

  initial begin
    int pat[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    bit pend[2] = '{1'b0, 1'b0};
    bit e0, rd;
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; be[p] = '0;
    end
    idle_inputs();
    avm_ready = 1'b0;
    avm_rdata = '0;
    repeat (3) cyc();
    chk("reset_err", arb_err, 0);
    chk("reset_size", avm_size, 1);
    rst_n = 1'b1;

    // Single read with return five cycles later
    cyc();
    rreq[0] = 1'b1; addr[0] = 27'h0000123; avm_ready = 1'b1;
    #1;
    chk("t2_burst", avm_burstbegin, 1);
    chk("t2_ready", m0_ready, 1);
    chk("t2_addr", avm_addr, 27'h0000123);
    cyc(); rreq[0] = 1'b0;
    repeat (3) cyc();
    cyc(); avm_rdata_valid = 1'b1; avm_rdata = 32'hDEADBEEF;
    #1;
    chk("t2_rv0", m0_rdata_valid, 1);
    chk("t2_rv1", m1_rdata_valid, 0);
    chk("t2_rdata", m0_rdata, 32'hDEADBEEF);
    cyc(); avm_rdata_valid = 1'b0;

    // Stall on m1 write; m0 must wait
    cyc();
    wreq[1] = 1'b1; addr[1] = 27'h00055AA; wdata[1] = 32'h12345678; be[1] = 4'hC; avm_ready = 1'b0;
    #1;
    chk("t3_burst0", avm_burstbegin, 1);
    chk("t3_m1_ready0", m1_ready, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); rreq[0] = 1'b1; addr[0] = 27'h77;
      #1;
      chk("t3_burst_hold", avm_burstbegin, 0);
      chk("t3_addr_hold", avm_addr, 27'h00055AA);
      chk("t3_m0_blocked", m0_ready, 0);
    end
    cyc(); avm_ready = 1'b1;
    #1;
    chk("t3_m1_ready", m1_ready, 1);
    chk("t3_be", avm_be, 4'hC);
    cyc(); wreq[1] = 1'b0;
    #1;
    chk("t3_m0_after", m0_ready, 1);
    chk("t3_m0_burst", avm_burstbegin, 1);
    cyc(); rreq[0] = 1'b0; avm_rdata_valid = 1'b1;
    cyc(); avm_rdata_valid = 1'b0;

    // Contention: both ports read every cycle, m1 won last
    wreq[1] = 1'b1;
    #1 chk("t4_pre", m1_ready, 1);
    cyc(); wreq[1] = 1'b0; rreq[0] = 1'b1; rreq[1] = 1'b1; addr[0] = 27'h100; addr[1] = 27'h200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      e0 = RR ? (i % 2 == 0) : 1'b1;
      #1;
      chk("t4_m0_grant", m0_ready, e0);
      chk("t4_m1_grant", m1_ready, !e0);
    end
    cyc(); rreq[0] = 1'b0; rreq[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      avm_rdata_valid = 1'b1; avm_rdata = $urandom;
      e0 = RR ? (i % 2 == 0) : 1'b1;
      #1 chk("t4_route", m0_rdata_valid, e0);
      cyc();
    end
    avm_rdata_valid = 1'b0;

    // Spurious return with empty FIFO sets sticky error
    cyc(); avm_rdata_valid = 1'b1;
    #1;
    chk("t6_rv", {m0_rdata_valid, m1_rdata_valid}, 0);
    cyc(); avm_rdata_valid = 1'b0;
    #1 chk("t6_err", arb_err, 1);
    repeat (3) cyc();
    chk("t6_err_sticky", arb_err, 1);

    // Reset asserted while holding port 0
    cyc(); rreq[0] = 1'b1; avm_ready = 1'b0;
    cyc();
    #1;
    chk("t1_hold_burst", avm_burstbegin, 0);
    chk("t1_hold_rd", avm_read_req, 1);
    rst_n = 1'b0; idle_inputs();
    #1;
    chk("t1_rst_rd", avm_read_req, 0);
    chk("t1_rst_err", arb_err, 0);
    cyc(); cyc(); rst_n = 1'b1;

    // Fill the tag FIFO, block the ninth read, let a write through, then drain in order
    avm_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); rreq[0] = (pat[i] == 0); rreq[1] = (pat[i] == 1);
      #1 chk("t5_issue", pat[i] == 0 ? m0_ready : m1_ready, 1);
    end
    cyc(); rreq[1] = 1'b0; rreq[0] = 1'b1; wreq[1] = 1'b1;
    #1;
    chk("t5_blocked_rd", avm_read_req, 0);
    chk("t5_blocked_m0", m0_ready, 0);
    chk("t5_write_ok", m1_ready, 1);
    cyc(); wreq[1] = 1'b0; avm_rdata_valid = 1'b1;
    #1;
    chk("t5_pop_route", m0_rdata_valid, 1);
    chk("t5_pop_noissue", m0_ready, 0);
    cyc(); avm_rdata_valid = 1'b0;
    #1 chk("t5_freed", m0_ready, 1);
    cyc(); rreq[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      avm_rdata_valid = 1'b1; avm_rdata = $urandom;
      #1;
      chk("t5_route1", m1_rdata_valid, (i < 7) ? pat[i+1] == 1 : 1'b0);
      chk("t5_route0", m0_rdata_valid, (i < 7) ? pat[i+1] == 0 : 1'b1);
      cyc();
    end
    avm_rdata_valid = 1'b0;

    // Randomized traffic with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n == 1500) begin
        rst_n = 1'b0; idle_inputs(); pend[0] = 1'b0; pend[1] = 1'b0;
        cyc(); cyc(); rst_n = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && acc[p]) pend[p] = 1'b0;
        if (!pend[p]) begin
          if ($urandom % 3 == 0) begin
            pend[p] = 1'b1;
            rd = $urandom % 2;
            rreq[p] = rd;
            wreq[p] = !rd || ($urandom % 16 == 0);
            addr[p] = AW'($urandom);
            wdata[p] = $urandom;
            be[p] = BW'($urandom);
          end else begin
            rreq[p] = 1'b0; wreq[p] = 1'b0;
          end
        end
      end
      avm_ready = ($urandom % 4 != 0);
      avm_rdata_valid = (q.size() > 0) && ($urandom % 3 == 0);
      avm_rdata = $urandom;
    end
    cyc(); idle_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
